urx: RTL and testbench
======================

Name: urx

Overview:
- 8N1 asynchronous serial receiver; the receive-side counterpart of the utx transmitter. It uses the same bit-period convention, so a utx and a urx with matching divisors interoperate.
- Synchronises the serial line, detects and validates the start bit, samples 8 data bits LSB first at mid-bit, and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe, or a one-cycle framing-error strobe.
- Sits between the external RX pin and the command/byte consumer in the LOST logger.

Parameters:
- BAUD_DIVISOR, 11'd433, bit period = BAUD_DIVISOR+1 clocks (same convention as utx); legal range 7..2047.
- HALF_BIT, (BAUD_DIVISOR+1)/2, clocks from start-edge detection to start-bit validation sample.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- serialin  input  1  asynchronous RX line; idles high.
- rxbyte  output  8  last good received byte; holds value until next good byte.
- valid  output  1  one-cycle pulse; rxbyte newly updated.
- framing_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - rxbyte=0, valid=0, framing_err=0, busy=0.
  - State=IDLE; counters=0.
  - Synchroniser flops and the edge-detect register reset to 1 (line idle).
  - Reset mid-frame abandons the frame with no strobes.
- Synchroniser: two flops on serialin, giving rxs. All decisions use rxs; the edge detector compares rxs to its 1-cycle delayed copy.
- Bit counter: 11-bit, cleared on every state entry, increments each clk while not IDLE. A data-bit index 0..7 tracks the DATA state.
- IDLE:
  - rxs falling edge (prev=1, now=0) -> START, counter=0.
- START:
  - At counter==HALF_BIT-1: if sample==0 -> DATA, counter=0, bit index=0.
  - If sample==1 -> IDLE (glitch rejected, no strobe).
- DATA:
  - At counter==BAUD_DIVISOR: sample shifted in at bit 7, register shifts right (LSB first); counter=0.
  - After bit index 7 sampled -> STOP.
- STOP:
  - At counter==BAUD_DIVISOR, sample==1: rxbyte<=shift reg, valid=1 next cycle, -> IDLE.
  - At counter==BAUD_DIVISOR, sample==0: framing_err=1 next cycle, rxbyte unchanged, -> BREAK.
- BREAK:
  - Wait for rxs==1, then -> IDLE. Prevents a held-low line (break) from being re-decoded as back-to-back 0x00 frames.
- Latency: valid asserts 2 sync + (HALF_BIT + 9*(BAUD_DIVISOR+1)) clocks after the serialin falling edge, ±1 clock depending on edge phase.
- valid and framing_err are registered, mutually exclusive, and never asserted during reset.
- Back-to-back frames: a start edge arriving immediately after the stop sample is accepted, because IDLE is re-entered on that same cycle. No minimum idle time is required beyond mid-stop.
- Unused state encodings recover to IDLE.

Optional Feature:
- Macro: URX_MAJORITY_VOTE_EN.
- Defined:
  - In START, DATA and STOP, the bit decision is the 2-of-3 majority of rxs captured at counter==D-2, D-1 and D, where D is the usual sample count (HALF_BIT-1 or BAUD_DIVISOR).
  - The decision is taken at counter==D, so timing is identical to the undefined case.
  - Requires BAUD_DIVISOR>=7.
- Undefined: single sample of rxs at counter==D. The vote registers are not synthesised.

Test Plan:
- BAUD_DIVISOR=9, drive 0xA5 as 8N1 (10 clk/bit) -> one valid pulse, rxbyte=0xA5, framing_err never set.
- Frames 0x00, 0xFF, 0x3C sent back-to-back with zero idle bits -> three valid pulses in order, rxbyte values 0x00, 0xFF, 0x3C.
- 2-clock low glitch on idle line -> START aborts at half-bit, no valid or framing_err, busy returns to 0, rxbyte unchanged.
- Frame 0x55 with stop bit forced low, line then held low 30 clocks and released -> exactly one framing_err pulse, no valid, rxbyte keeps prior value, busy stays 1 until the line goes high.
- rst asserted during bit 4 of a frame -> all outputs 0 immediately. Next clean 0x81 frame is received correctly.
- With URX_MAJORITY_VOTE_EN: 1-clock inverted spike at the mid-bit of each data bit of 0xC3 -> rxbyte=0xC3. Without the macro, the same stimulus yields a corrupted byte.

Source files
------------

// File: rtl/urx.sv
// rtl/urx.sv - 8N1 serial receiver with start-bit validation, framing check and break hold-off.
// Optional 2-of-3 mid-bit vote enabled by defining URX_MAJORITY_VOTE_EN.
module urx #(
    parameter logic [10:0] BAUD_DIVISOR = 11'd433,
    parameter logic [10:0] HALF_BIT     = 11'((12'(BAUD_DIVISOR) + 12'd1) >> 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serialin,
    output logic [7:0] rxbyte,
    output logic       valid,
    output logic       framing_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [10:0] START_D = HALF_BIT - 11'd1;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rxs_q, rxs_d;
    logic        prev_q, prev_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rxbyte_q, rxbyte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;

    logic [10:0] d_cnt;
    logic        at_d;
    logic        bit_val;

    always_comb begin
        d_cnt = (state_q == START) ? START_D : BAUD_DIVISOR;
        at_d  = (cnt_q == d_cnt);
    end

`ifdef URX_MAJORITY_VOTE_EN
    logic vote0_q, vote0_d;
    logic vote1_q, vote1_d;

    // The two earlier captures join the live sample at counter==D, so decision timing is unchanged.
    always_comb begin
        vote0_d = vote0_q;
        vote1_d = vote1_q;
        if (cnt_q == d_cnt - 11'd2) vote0_d = rxs_q;
        if (cnt_q == d_cnt - 11'd1) vote1_d = rxs_q;
        bit_val = (vote0_q & vote1_q) | (vote0_q & rxs_q) | (vote1_q & rxs_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            vote0_q <= vote0_d;
            vote1_q <= vote1_d;
        end
    end
`else
    always_comb begin
        bit_val = rxs_q;
    end
`endif

    always_comb begin
        sync1_d   = serialin;
        rxs_d     = sync1_q;
        prev_d    = rxs_q;
        state_d   = state_q;
        cnt_d     = (state_q == IDLE) ? 11'd0 : cnt_q + 11'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rxbyte_d  = rxbyte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (prev_q && !rxs_q) begin
                    state_d = START;
                    cnt_d   = 11'd0;
                end
            end
            START: begin
                if (at_d) begin
                    cnt_d     = 11'd0;
                    bit_idx_d = 3'd0;
                    state_d   = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_d) begin
                    cnt_d     = 11'd0;
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (at_d) begin
                    cnt_d = 11'd0;
                    if (bit_val) begin
                        rxbyte_d = shift_q;
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must rise before another start edge can be seen.
                if (rxs_q) begin
                    state_d = IDLE;
                    cnt_d   = 11'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 11'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= 11'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            rxbyte_q  <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            rxs_q     <= rxs_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rxbyte_q  <= rxbyte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign rxbyte      = rxbyte_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_urx.sv
// tb/tb_urx.sv - scoreboard bench for urx at BAUD_DIVISOR=9 (10 clocks per bit).
module tb_urx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serialin = 1'b1;
    logic [7:0] rxbyte;
    logic       valid;
    logic       framing_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    urx #(.BAUD_DIVISOR(11'd9)) dut (
        .clk         (clk),
        .rst         (rst),
        .serialin    (serialin),
        .rxbyte      (rxbyte),
        .valid       (valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        serialin = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len, input bit spike);
        drive(1'b0, 10);
        for (int i = 0; i < 8; i++) begin
            if (spike) begin
                drive(b[i], 5);
                drive(~b[i], 1);
                drive(b[i], 4);
            end else begin
                drive(b[i], 10);
            end
        end
        drive(stop_v, stop_len);
    endtask

    task automatic expect_evt(input logic is_err, input logic [7:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && framing_err) check("strobes_exclusive", 32'd1, 32'd0);
            if (valid || framing_err) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got valid=%0b framing_err=%0b rxbyte=%0h expected none",
                             valid, framing_err, rxbyte);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_kind", {31'd0, framing_err}, {31'd0, e.is_err});
                    check("strobe_rxbyte", {24'd0, rxbyte}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        logic [7:0] spike_exp;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rxbyte", {24'd0, rxbyte}, 32'h0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_ferr", {31'd0, framing_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 5);

        expect_evt(1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1, 10, 1'b0);
        drive(1'b1, 10);
        check("a5_busy_idle", {31'd0, busy}, 32'd0);
        check("a5_rxbyte_held", {24'd0, rxbyte}, 32'hA5);

        expect_evt(1'b0, 8'h00);
        expect_evt(1'b0, 8'hFF);
        expect_evt(1'b0, 8'h3C);
        send_frame(8'h00, 1'b1, 10, 1'b0);
        send_frame(8'hFF, 1'b1, 10, 1'b0);
        send_frame(8'h3C, 1'b1, 10, 1'b0);
        drive(1'b1, 20);
        check("b2b_rxbyte", {24'd0, rxbyte}, 32'h3C);

        drive(1'b0, 2);
        drive(1'b1, 2);
        check("glitch_busy_start", {31'd0, busy}, 32'd1);
        drive(1'b1, 10);
        check("glitch_busy_done", {31'd0, busy}, 32'd0);
        check("glitch_rxbyte", {24'd0, rxbyte}, 32'h3C);

        expect_evt(1'b1, 8'h3C);
        send_frame(8'h55, 1'b0, 40, 1'b0);
        check("break_busy_low", {31'd0, busy}, 32'd1);
        drive(1'b1, 5);
        check("break_busy_released", {31'd0, busy}, 32'd0);
        check("break_rxbyte", {24'd0, rxbyte}, 32'h3C);

        drive(1'b0, 10);
        for (int i = 0; i < 4; i++) drive(i[0], 10);
        drive(1'b1, 5);
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        serialin = 1'b1;
        #1;
        check("rst_rxbyte", {24'd0, rxbyte}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, framing_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 10);
        expect_evt(1'b0, 8'h81);
        send_frame(8'h81, 1'b1, 10, 1'b0);
        drive(1'b1, 10);
        check("after_rst_rxbyte", {24'd0, rxbyte}, 32'h81);

`ifdef URX_MAJORITY_VOTE_EN
        spike_exp = 8'hC3;
`else
        spike_exp = 8'h3C;
`endif
        expect_evt(1'b0, spike_exp);
        send_frame(8'hC3, 1'b1, 10, 1'b1);
        drive(1'b1, 20);
        check("spike_rxbyte", {24'd0, rxbyte}, {24'd0, spike_exp});
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
